bcd_updown_counter: RTL

Parametrised multi-digit up/down counter for the calculator datapath and display path. It generalises the single-digit mod-10 counter to N cascaded digits with a configurable per-digit radix. It adds synchronous reset, enable, direction control, parallel load, and wrap or saturate behaviour. The packed digit output feeds the seven-segment display driver directly, and the terminal-count output chains into further counters.

---
 rtl/bcd_updown_counter_if.sv | 13 +
 rtl/bcd_updown_counter.sv | 65 ++++++
 2 files changed

// File: rtl/bcd_updown_counter_if.sv
// bcd_updown_counter_if: control and status bundle for the cascaded digit counter
interface bcd_updown_counter_if #(parameter int DIGITS = 4);
  logic en;
  logic up;
  logic load;
  logic [4*DIGITS-1:0] load_val;
  logic [4*DIGITS-1:0] count;
  logic tc;
  logic wrap;
  logic ovf;
  modport master(output en, up, load, load_val, input count, tc, wrap, ovf);
  modport slave(input en, up, load, load_val, output count, tc, wrap, ovf);
endinterface

// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter: N-digit radix-R up/down counter with load, wrap/saturate and sticky overflow
module bcd_updown_counter #(
  parameter int DIGITS = 4,
  parameter int RADIX = 10,
  parameter int SATURATE = 0
) (
  input logic clk,
  input logic rst,
  bcd_updown_counter_if.slave bus
);
  localparam int W = 4 * DIGITS;
  localparam logic [3:0] MAX = 4'(RADIX - 1);
  localparam logic SAT = SATURATE != 0;
  logic [W-1:0] count_q;
  logic [W-1:0] step;
  logic [W-1:0] clean;
  logic [3:0] d;
  logic [3:0] ld;
  logic all_max;
  logic all_zero;
  logic carry;
  logic wrap_q;
  logic ovf_q;
  // ripple the carry/borrow through the digits, detect extremes, and scrub out-of-range load digits
  always_comb begin
    step = '0;
    clean = '0;
    d = '0;
    ld = '0;
    all_max = 1'b1;
    all_zero = 1'b1;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = count_q[4*i+:4];
      ld = bus.load_val[4*i+:4];
      all_max = all_max & (d == MAX);
      all_zero = all_zero & (d == 4'd0);
      step[4*i+:4] = !carry ? d : bus.up ? (d == MAX ? 4'd0 : d + 4'd1) : (d == 4'd0 ? MAX : d - 4'd1);
      carry = carry & (bus.up ? d == MAX : d == 4'd0);
      clean[4*i+:4] = ld > MAX ? 4'd0 : ld;
    end
  end
  assign bus.tc = bus.en & (bus.up ? all_max : all_zero);
  assign bus.count = count_q;
  assign bus.wrap = wrap_q;
  assign bus.ovf = ovf_q;
  // reset beats load beats count; at an extreme either roll over with a wrap pulse or clamp
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      wrap_q <= 1'b0;
      ovf_q <= 1'b0;
    end else if (bus.load) begin
      count_q <= clean;
      wrap_q <= 1'b0;
      ovf_q <= 1'b0;
    end else if (bus.en) begin
      count_q <= (bus.tc && SAT) ? count_q : step;
      wrap_q <= bus.tc && !SAT;
      ovf_q <= ovf_q | bus.tc;
    end else begin
      wrap_q <= 1'b0;
    end
  end
endmodule
